alu_result_stage: RTL and testbench

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage_if.sv | 32 +++
 rtl/alu_result_stage.sv | 113 +++++++++++
 tb/tb_alu_result_stage.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_stage_if.sv
// Handshake and adder bundle for alu_result_stage.
// master is the environment side, slave is the stage.
interface alu_result_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_sub;
    logic [15:0] add_sum;
    logic        add_ovfl;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  flags;

    modport master (
        output in_valid, in_op, in_a, in_b,
        output add_sum, add_ovfl, out_ready,
        input  in_ready, add_a, add_b, add_sub,
        input  out_valid, out_data, flags
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b,
        input  add_sum, add_ovfl, out_ready,
        output in_ready, add_a, add_b, add_sub,
        output out_valid, out_data, flags
    );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result stage: ADD/SUB/XOR in one cycle, RED (byte-sum) in two.
// Define ALU_SAT_EN to saturate ADD/SUB results on signed overflow.
module alu_result_stage (
    input  logic              clk,
    input  logic              rst,
    alu_result_stage_if.slave bus
);
    typedef enum logic {S_IDLE, S_RED2} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_t;
    logic [15:0] r_out_data;
    logic        r_out_valid;
    logic [3:0]  r_flags;

    logic        w_in_ready;
    logic        w_in_xfer;
    logic        w_out_xfer;
    logic [15:0] w_add_a;
    logic [15:0] w_add_b;
    logic        w_add_sub;
    logic        w_b_sign;
    logic        w_v;
    logic [15:0] w_res;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_in_xfer && bus.in_op == 2'b11) w_next = S_RED2;
            S_RED2: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        w_add_a    = bus.in_a;
        w_add_b    = bus.in_b;
        w_add_sub  = (bus.in_op == 2'b01);
        unique case (r_state)
            S_IDLE: w_in_ready = !r_out_valid || bus.out_ready;
            S_RED2: begin
                w_add_a   = {{8{r_t[15]}}, r_t[15:8]};
                w_add_b   = {{8{r_t[7]}}, r_t[7:0]};
                w_add_sub = 1'b0;
            end
        endcase
    end

    assign w_in_xfer  = bus.in_valid && w_in_ready;
    assign w_out_xfer = r_out_valid && bus.out_ready;

    // Subtraction flips the effective sign of the second operand.
    assign w_b_sign = bus.in_b[15] ^ w_add_sub;
    assign w_v = (bus.in_a[15] == w_b_sign) &&
                 (bus.add_sum[15] != bus.in_a[15]);

`ifdef ALU_SAT_EN
    assign w_res = !w_v         ? bus.add_sum :
                   bus.in_a[15] ? 16'h8000    : 16'h7FFF;
`else
    assign w_res = bus.add_sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 16'h0000;
            r_flags     <= 4'b0000;
            r_t         <= 16'h0000;
        end else if (r_state == S_RED2) begin
            // Output slot was freed when the RED op was accepted.
            r_out_data  <= bus.add_sum;
            r_out_valid <= 1'b1;
            r_flags[3]  <= (bus.add_sum == 16'h0000);
            r_flags[1]  <= bus.add_sum[15];
        end else if (w_in_xfer) begin
            unique case (bus.in_op)
                2'b00, 2'b01: begin
                    r_out_data  <= w_res;
                    r_out_valid <= 1'b1;
                    r_flags     <= {w_res == 16'h0000, w_v,
                                    w_res[15], bus.add_ovfl};
                end
                2'b10: begin
                    r_out_data  <= bus.in_a ^ bus.in_b;
                    r_out_valid <= 1'b1;
                    r_flags[3]  <= ((bus.in_a ^ bus.in_b) == 16'h0000);
                    r_flags[1]  <= bus.in_a[15] ^ bus.in_b[15];
                end
                2'b11: begin
                    r_t <= bus.add_sum;
                    if (w_out_xfer) r_out_valid <= 1'b0;
                end
            endcase
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.add_a     = w_add_a;
    assign bus.add_b     = w_add_b;
    assign bus.add_sub   = w_add_sub;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.flags     = r_flags;
endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage with an external adder model.
// Vector table, corner sequences, then randomized traffic vs a reference.
module tb_alu_result_stage;
`ifdef ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    alu_result_stage_if bus ();

    alu_result_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign {bus.add_ovfl, bus.add_sum} = bus.add_sub ?
        ({1'b0, bus.add_a} - {1'b0, bus.add_b}) :
        ({1'b0, bus.add_a} + {1'b0, bus.add_b});

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_d;
        logic [3:0]  exp_f;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Reference: result and {Z,V,N,C} from plain integer arithmetic.
    function automatic logic [19:0] ref_alu(input logic [1:0] op,
        input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
        int s, u;
        logic [15:0] r, t;
        logic v, c;
        v = f[2];
        c = f[0];
        r = 16'h0000;
        case (op)
            2'b00, 2'b01: begin
                if (op == 2'b00) begin
                    s = int'($signed(a)) + int'($signed(b));
                    u = int'(a) + int'(b);
                    c = (u > 65535);
                end else begin
                    s = int'($signed(a)) - int'($signed(b));
                    u = int'(a) - int'(b);
                    c = (a < b);
                end
                v = (s > 32767) || (s < -32768);
                r = u[15:0];
                if (SAT && v) r = (s > 0) ? 16'h7FFF : 16'h8000;
            end
            2'b10: r = a ^ b;
            default: begin
                t = a + b;
                s = int'($signed(t[15:8])) + int'($signed(t[7:0]));
                r = s[15:0];
            end
        endcase
        return {r, r == 16'h0000, v, r[15], c};
    endfunction

    initial begin
        bit mv, busy, xin, xout, rdy;
        logic [15:0] md, pend;
        logic [3:0]  mf;
        logic [19:0] rr;
        logic [1:0]  op;
        logic [15:0] a, b;

        tbl[0] = '{2'b00, 16'h7FFF, 16'h0001,
                   SAT ? 16'h7FFF : 16'h8000, SAT ? 4'b0100 : 4'b0110};
        tbl[1] = '{2'b01, 16'h0003, 16'h0005, 16'hFFFE, 4'b0011};
        tbl[2] = '{2'b11, 16'h0102, 16'h0304, 16'h000A, 4'b0000};
        tbl[3] = '{2'b10, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b1000};
        tbl[4] = '{2'b00, 16'hFFFF, 16'h0001, 16'h0000, 4'b1001};
        tbl[5] = '{2'b01, 16'h8000, 16'h0001,
                   SAT ? 16'h8000 : 16'h7FFF, SAT ? 4'b0110 : 4'b0100};
        tbl[6] = '{2'b00, 16'h8000, 16'h8000,
                   SAT ? 16'h8000 : 16'h0000, SAT ? 4'b0111 : 4'b1101};
        tbl[7] = '{2'b11, 16'h7F80, 16'h0000, 16'hFFFF, 4'b0010};
        tbl[8] = '{2'b10, 16'h1234, 16'h00FF, 16'h12CB, 4'b0000};

        bus.in_valid = 1'b0;
        bus.in_op = 2'b00;
        bus.in_a = 16'h0;
        bus.in_b = 16'h0;
        bus.out_ready = 1'b0;
        #1;
        do_reset();
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset out_data", 32'(bus.out_data), 32'h0);
        chk("reset flags", 32'(bus.flags), 32'h0);
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);

        foreach (tbl[i]) begin
            do_reset();
            bus.out_ready = 1'b1;
            bus.in_valid = 1'b1;
            bus.in_op = tbl[i].op;
            bus.in_a = tbl[i].a;
            bus.in_b = tbl[i].b;
            step();
            bus.in_valid = 1'b0;
            if (tbl[i].op == 2'b11) begin
                chk($sformatf("vec%0d red2 in_ready", i),
                    32'(bus.in_ready), 32'd0);
                chk($sformatf("vec%0d red2 valid", i),
                    32'(bus.out_valid), 32'd0);
                step();
            end
            chk($sformatf("vec%0d valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("vec%0d data", i), 32'(bus.out_data),
                32'(tbl[i].exp_d));
            chk($sformatf("vec%0d flags", i), 32'(bus.flags),
                32'(tbl[i].exp_f));
        end

        // Output hold under backpressure.
        do_reset();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_op = 2'b10;
        bus.in_a = 16'hAAAA;
        bus.in_b = 16'hAAAA;
        step();
        bus.in_op = 2'b00;
        bus.in_a = 16'h1111;
        for (int k = 0; k < 3; k++) begin
            chk("hold in_ready", 32'(bus.in_ready), 32'd0);
            step();
            chk("hold valid", 32'(bus.out_valid), 32'd1);
            chk("hold data", 32'(bus.out_data), 32'h0);
            chk("hold flags", 32'(bus.flags), 32'h8);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("release in_ready", 32'(bus.in_ready), 32'd1);
        step();
        chk("release valid", 32'(bus.out_valid), 32'd0);

        // Back-to-back ADDs with no bubbles.
        bus.in_valid = 1'b1;
        bus.in_op = 2'b00;
        for (int k = 0; k < 5; k++) begin
            bus.in_a = 16'(k * 300);
            bus.in_b = 16'(k + 7);
            #1;
            chk("b2b in_ready", 32'(bus.in_ready), 32'd1);
            step();
            chk("b2b valid", 32'(bus.out_valid), 32'd1);
            chk("b2b data", 32'(bus.out_data), 32'(k * 301 + 7));
        end
        bus.in_valid = 1'b0;

        // Reset while the RED op is in its second cycle.
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_op = 2'b01;
        bus.in_a = 16'h0003;
        bus.in_b = 16'h0005;
        step();
        bus.in_op = 2'b11;
        bus.in_a = 16'h0102;
        bus.in_b = 16'h0304;
        step();
        bus.in_valid = 1'b0;
        chk("rstred in red2", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstred valid", 32'(bus.out_valid), 32'd0);
        chk("rstred flags", 32'(bus.flags), 32'h0);
        chk("rstred in_ready", 32'(bus.in_ready), 32'd1);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("rstred no result", 32'(bus.out_valid), 32'd0);
            chk("rstred data", 32'(bus.out_data), 32'h0);
        end

        // Randomized traffic against the reference model.
        do_reset();
        mv = 1'b0; busy = 1'b0;
        md = 16'h0; mf = 4'h0; pend = 16'h0;
        for (int k = 0; k < 400; k++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0: begin a = 16'h7FFF; b = 16'($urandom); end
                1: begin a = 16'h8000; b = 16'($urandom); end
                default: begin a = 16'($urandom); b = 16'($urandom); end
            endcase
            bus.in_valid = 1'($urandom_range(0, 3) != 0);
            bus.out_ready = 1'($urandom_range(0, 2) != 0);
            bus.in_op = op;
            bus.in_a = a;
            bus.in_b = b;
            #1;
            rdy = !busy && (!mv || bus.out_ready);
            chk("rand in_ready", 32'(bus.in_ready), 32'(rdy));
            xin = bus.in_valid && rdy;
            xout = mv && bus.out_ready;
            if (busy) begin
                md = pend;
                mv = 1'b1;
                mf = {pend == 16'h0, mf[2], pend[15], mf[0]};
                busy = 1'b0;
            end else if (xin && op == 2'b11) begin
                rr = ref_alu(op, a, b, mf);
                pend = rr[19:4];
                busy = 1'b1;
                if (xout) mv = 1'b0;
            end else if (xin) begin
                rr = ref_alu(op, a, b, mf);
                md = rr[19:4];
                mf = rr[3:0];
                mv = 1'b1;
            end else if (xout) begin
                mv = 1'b0;
            end
            step();
            chk("rand valid", 32'(bus.out_valid), 32'(mv));
            chk("rand data", 32'(bus.out_data), 32'(md));
            chk("rand flags", 32'(bus.flags), 32'(mf));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
